// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Instruction-memory load writer. Writes a received byte
//               stream to consecutive byte addresses, assembles big-endian
//               words, and ends the load on a word-aligned HALT instruction
//               or when the last memory address has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
    parameter int                    DATA_SIZE  = 8,
    parameter int                    ADDR_SIZE  = 8,
    parameter int                    INST_SIZE  = 32,
    parameter logic [INST_SIZE-1:0]  HALT_INSTR = 32'hFFFFFFFF
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [DATA_SIZE-1:0]   i_rx_data,
    input  logic                   i_rx_done,
    output logic                   o_write_en,
    output logic                   o_instrmem_en,
    output logic [DATA_SIZE-1:0]   o_write_data,
    output logic [ADDR_SIZE-1:0]   o_write_addr,
    output logic [ADDR_SIZE-2:0]   o_instr_count,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_full
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = {ADDR_SIZE{1'b1}};

    logic [1:0]             state;
    logic [ADDR_SIZE-1:0]   addr;
    logic [1:0]             byte_cnt;
    logic [INST_SIZE-1:0]   word;
    // Set together with the final write; the load closes one cycle later
    // so the final write pulse is still seen while busy.
    logic                   stop;
    logic                   write_en;
    logic [DATA_SIZE-1:0]   write_data;
    logic [ADDR_SIZE-1:0]   write_addr;
    logic [ADDR_SIZE-2:0]   instr_count;
    logic                   full;

    logic [INST_SIZE-1:0]   next_word;
    logic                   halt_hit;
    logic                   last_byte;

    assign next_word = {word[INST_SIZE-DATA_SIZE-1:0], i_rx_data};
    assign last_byte = (byte_cnt == 2'd3);
    assign halt_hit  = last_byte && (next_word == HALT_INSTR);

    // Load sequencer: byte capture, word assembly and termination.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            addr        <= '0;
            byte_cnt    <= 2'd0;
            word        <= '0;
            stop        <= 1'b0;
            write_en    <= 1'b0;
            write_data  <= '0;
            write_addr  <= '0;
            instr_count <= '0;
            full        <= 1'b0;
        end else begin
            write_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // A byte arriving with the start pulse is discarded.
                    if (i_start) begin
                        state       <= LOAD;
                        addr        <= '0;
                        byte_cnt    <= 2'd0;
                        word        <= '0;
                        stop        <= 1'b0;
                        instr_count <= '0;
                        full        <= 1'b0;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        state <= DONE;
                    end else if (i_rx_done) begin
                        write_en   <= 1'b1;
                        write_data <= i_rx_data;
                        write_addr <= addr;
                        word       <= next_word;
                        byte_cnt   <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            instr_count <= instr_count + (ADDR_SIZE-1)'(1);
                        end
                        // The address saturates at the top so it never
                        // wraps back onto already loaded code.
                        if (addr == LAST_ADDR) begin
                            full <= 1'b1;
                            stop <= 1'b1;
                        end else begin
                            addr <= addr + ADDR_SIZE'(1);
                        end
                        if (halt_hit) begin
                            stop <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_write_en    = write_en;
    assign o_write_data  = write_data;
    assign o_write_addr  = write_addr;
    assign o_instr_count = instr_count;
    assign o_full        = full;
    assign o_busy        = (state == LOAD);
    assign o_instrmem_en = (state == LOAD);
    assign o_done        = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Self-checking bench for instr_mem_loader. Byte streams are
//               scored against a list-level model of the load rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       write_en;
    logic       instrmem_en;
    logic [7:0] write_data;
    logic [7:0] write_addr;
    logic [6:0] instr_count;
    logic       busy;
    logic       done;
    logic       full;

    int checks = 0;
    int errors = 0;

    instr_mem_loader dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_rx_data     (rx_data),
        .i_rx_done     (rx_done),
        .o_write_en    (write_en),
        .o_instrmem_en (instrmem_en),
        .o_write_data  (write_data),
        .o_write_addr  (write_addr),
        .o_instr_count (instr_count),
        .o_busy        (busy),
        .o_done        (done),
        .o_full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: how many leading bytes of a stream get written, and why
    // the load ended (HALT on a word boundary, or the 256th byte).
    function automatic void model(input logic [7:0] b[$], output int n,
                                  output bit full_e, output bit term);
        logic [31:0] w;
        w = 32'h0;
        n = b.size();
        full_e = 1'b0;
        term = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            w = {w[23:0], b[i]};
            if (i == 255) begin
                n = i + 1; full_e = 1'b1; term = 1'b1; break;
            end
            if ((i % 4) == 3 && w == 32'hFFFFFFFF) begin
                n = i + 1; term = 1'b1; break;
            end
        end
    endfunction

    task automatic cycle_check(input bit exp_we, input logic [7:0] d, input int a,
                               input int nw, input bit done_e);
        chk("write_en", write_en, exp_we);
        if (exp_we) begin
            chk("write_data", write_data, d);
            chk("write_addr", write_addr, a);
        end
        chk("instr_count", instr_count, nw / 4);
        chk("done", done, done_e);
        chk("busy", busy, !done_e);
        chk("instrmem_en", instrmem_en, !done_e);
    endtask

    task automatic do_start(input bit with_rx);
        start = 1'b1;
        rx_done = with_rx;
        rx_data = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        rx_done = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_done", done, 1'b0);
        chk("start_count", instr_count, 0);
        chk("start_full", full, 1'b0);
        chk("start_we", write_en, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_done = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_we", write_en, 1'b0);
        chk("rst_mem_en", instrmem_en, 1'b0);
        chk("rst_data", write_data, 0);
        chk("rst_addr", write_addr, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_full", full, 1'b0);
    endtask

    // Drives a stream from the start of a load and checks every cycle.
    task automatic run_stream(input logic [7:0] b[$], input bit b2b,
                              input int start_at, output bit term);
        int  n;
        int  nw;
        bit  full_e;
        bit  ended;
        model(b, n, full_e, term);
        nw = 0;
        ended = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            if (i == start_at && i < n) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                cycle_check(1'b0, 8'h0, 0, nw, ended);
            end
            if (!b2b) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    cycle_check(1'b0, 8'h0, 0, nw, ended);
                end
            end
            rx_done = 1'b1;
            rx_data = b[i];
            @(negedge clk);
            rx_done = 1'b0;
            if (i < n) nw++;
            cycle_check(i < n, b[i], i, nw, ended);
            if (term && nw == n) ended = 1'b1;
        end
        @(negedge clk);
        cycle_check(1'b0, 8'h0, 0, nw, ended);
        chk("final_full", full, full_e);
        chk("final_done", done, term);
        chk("final_count", instr_count, n / 4);
    endtask

    initial begin
        logic [7:0] q[$];
        bit         term;
        int         len;

        rst = 1'b1;
        start = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h0;
        repeat (2) @(negedge clk);
        do_reset();

        // Strobe in IDLE is ignored.
        rx_done = 1'b1; rx_data = 8'h55;
        @(negedge clk);
        rx_done = 1'b0;
        chk("idle_rx_we", write_en, 1'b0);
        chk("idle_rx_busy", busy, 1'b0);

        // Normal load terminated by HALT.
        do_start(1'b0);
        q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_stream(q, 1'b0, -1, term);

        // Strobe in DONE is ignored.
        rx_done = 1'b1; rx_data = 8'h77;
        @(negedge clk);
        rx_done = 1'b0;
        chk("done_rx_we", write_en, 1'b0);
        chk("done_rx_done", done, 1'b1);
        chk("done_hold_count", instr_count, 3);

        // Restart from DONE with a simultaneous strobe; unaligned all-ones.
        do_start(1'b1);
        q = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_stream(q, 1'b0, -1, term);

        // Fill the whole memory; extra bytes must not be written.
        do_start(1'b0);
        q = {};
        for (int i = 0; i < 258; i++) q.push_back(8'h11);
        run_stream(q, 1'b1, -1, term);

        // Back-to-back strobes, start ignored during LOAD, then reset mid-load.
        do_start(1'b0);
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02};
        run_stream(q, 1'b1, 4, term);
        chk("b2b_busy", busy, 1'b1);
        do_reset();

        // Randomized loads.
        for (int k = 0; k < 12; k++) begin
            do_start($urandom_range(0, 1) == 1);
            len = $urandom_range(1, 40);
            q = {};
            for (int i = 0; i < len; i++)
                q.push_back(($urandom_range(0, 2) == 0) ? 8'h3C : 8'hFF);
            for (int i = 0; i < len; i++)
                if ($urandom_range(0, 3) == 0) q[i] = 8'($urandom);
            run_stream(q, $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1,
                       term);
            if (!term) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
